// File: rtl/mem_port_arbiter.sv
// ============================================================================
//  Module   : mem_port_arbiter
//  Brief    : Shares one memory port between an instruction-fetch port and a
//             data port. At most one transaction is outstanding at a time.
//             The optional starvation guard is enabled by the macro
//             MEM_ARB_STARVE_GUARD_EN.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_port_arbiter #(
   parameter int STARVE_LIMIT = 4
) (
   input  logic        clk,
   input  logic        reset_n,
   // instruction-fetch port
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic        if_gnt,
   output logic        if_rvalid,
   output logic [31:0] if_rdata,
   // data port
   input  logic        d_req,
   input  logic        d_we,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   input  logic [3:0]  d_be,
   output logic        d_gnt,
   output logic        d_rvalid,
   output logic [31:0] d_rdata,
   // shared memory port
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_be,
   input  logic        mem_gnt,
   input  logic        mem_rvalid,
   input  logic [31:0] mem_rdata,
   output logic        err
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_BUSY_I = 2'd1,
      S_BUSY_D = 2'd2
   } state_t;

   state_t r_state;
   state_t w_next;
   logic   r_err;
   logic   w_force_if;
   logic   w_sel_d;
   logic   w_sel_i;

`ifdef MEM_ARB_STARVE_GUARD_EN
   localparam int c_CW_RAW = $clog2(STARVE_LIMIT + 1);
   localparam int c_CNT_W  = (c_CW_RAW < 3) ? 3 : c_CW_RAW;
   localparam logic [c_CNT_W-1:0] c_LIMIT = c_CNT_W'(STARVE_LIMIT);

   logic [c_CNT_W-1:0] r_starve_cnt;

   assign w_force_if = if_req && (r_starve_cnt == c_LIMIT);

   // Counts data grants that overtook a waiting fetch.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_starve_cnt <= '0;
      end else if (if_gnt) begin
         r_starve_cnt <= '0;
      end else if (d_gnt && if_req && (r_starve_cnt != c_LIMIT)) begin
         r_starve_cnt <= r_starve_cnt + 1'b1;
      end
   end
`else
   // Limit has no effect without the guard; constant false.
   assign w_force_if = (STARVE_LIMIT < 0);
`endif

   assign w_sel_d = d_req && !w_force_if;
   assign w_sel_i = if_req && !w_sel_d;
   assign err     = r_err;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next    = r_state;
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = 32'd0;
      mem_wdata = 32'd0;
      mem_be    = 4'd0;
      if_gnt    = 1'b0;
      d_gnt     = 1'b0;
      if_rvalid = 1'b0;
      if_rdata  = 32'd0;
      d_rvalid  = 1'b0;
      d_rdata   = 32'd0;
      case (r_state)
         S_IDLE: begin
            // Reset gating keeps the request path quiet while reset is held.
            if (reset_n) begin
               mem_req = w_sel_d || w_sel_i;
               if (w_sel_d) begin
                  mem_we    = d_we;
                  mem_addr  = d_addr;
                  mem_wdata = d_wdata;
                  mem_be    = d_be;
               end else if (w_sel_i) begin
                  mem_addr  = if_addr;
                  mem_be    = 4'b1111;
               end
               if (mem_gnt && w_sel_d) begin
                  d_gnt  = 1'b1;
                  w_next = S_BUSY_D;
               end else if (mem_gnt && w_sel_i) begin
                  if_gnt = 1'b1;
                  w_next = S_BUSY_I;
               end
            end
         end
         S_BUSY_I: begin
            if (mem_rvalid) begin
               if_rvalid = 1'b1;
               if_rdata  = mem_rdata;
               w_next    = S_IDLE;
            end
         end
         S_BUSY_D: begin
            if (mem_rvalid) begin
               d_rvalid = 1'b1;
               d_rdata  = mem_rdata;
               w_next   = S_IDLE;
            end
         end
         default: begin
            w_next = S_IDLE;
         end
      endcase
   end

   // A response with nothing outstanding is a protocol error; sticky until reset.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_err <= 1'b0;
      end else if ((r_state == S_IDLE) && mem_rvalid) begin
         r_err <= 1'b1;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// ============================================================================
//  Module   : tb_mem_port_arbiter
//  Brief    : Directed self-checking bench for mem_port_arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_port_arbiter;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        if_req;
   logic [31:0] if_addr;
   logic        if_gnt, if_rvalid;
   logic [31:0] if_rdata;
   logic        d_req, d_we;
   logic [31:0] d_addr, d_wdata;
   logic [3:0]  d_be;
   logic        d_gnt, d_rvalid;
   logic [31:0] d_rdata;
   logic        mem_req, mem_we;
   logic [31:0] mem_addr, mem_wdata;
   logic [3:0]  mem_be;
   logic        mem_gnt, mem_rvalid;
   logic [31:0] mem_rdata;
   logic        err;

   int checks   = 0;
   int failures = 0;

   mem_port_arbiter #(.STARVE_LIMIT(4)) dut (
      .clk(clk), .reset_n(reset_n),
      .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
      .if_rvalid(if_rvalid), .if_rdata(if_rdata),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_be(d_be), .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_gnt(mem_gnt),
      .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .err(err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Advance to the next falling edge; inputs change there, checks follow #1.
   task automatic step();
      @(negedge clk);
   endtask

   // 1 = data grant, 0 = fetch grant, for six back-to-back arbitrations.
`ifdef MEM_ARB_STARVE_GUARD_EN
   logic [5:0] starve_seq = 6'b101111;
`else
   logic [5:0] starve_seq = 6'b111111;
`endif

   initial begin
      reset_n = 1'b0;
      if_req = 1'b1; if_addr = 32'h0000_0040;
      d_req = 1'b1; d_we = 1'b1; d_addr = 32'h0000_0080;
      d_wdata = 32'h1111_2222; d_be = 4'hF;
      mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h5555_AAAA;

      // Reset holds every request/grant/response output low.
      step(); #1;
      chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
      chk("rst_gnts", {30'd0, if_gnt, d_gnt}, 32'd0);
      chk("rst_rvalids", {30'd0, if_rvalid, d_rvalid}, 32'd0);
      chk("rst_mem_addr", mem_addr, 32'd0);
      chk("rst_err", {31'd0, err}, 32'd0);

      step();
      reset_n = 1'b1;
      if_req = 1'b0; d_req = 1'b0; d_we = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0;
      #1;
      chk("idle_mem_req", {31'd0, mem_req}, 32'd0);
      chk("idle_mem_be", {28'd0, mem_be}, 32'd0);
      chk("idle_mem_wdata", mem_wdata, 32'd0);

      // Single fetch.
      step();
      if_req = 1'b1; if_addr = 32'h0000_0100; mem_gnt = 1'b1;
      #1;
      chk("f_mem_addr", mem_addr, 32'h0000_0100);
      chk("f_if_gnt", {31'd0, if_gnt}, 32'd1);
      chk("f_d_gnt", {31'd0, d_gnt}, 32'd0);
      chk("f_mem_we", {31'd0, mem_we}, 32'd0);
      chk("f_mem_be", {28'd0, mem_be}, 32'hF);
      chk("f_mem_wdata", mem_wdata, 32'd0);
      step();
      if_addr = 32'h0000_0104;
      #1;
      chk("f_busy_req", {31'd0, mem_req}, 32'd0);
      chk("f_busy_gnt", {31'd0, if_gnt}, 32'd0);
      chk("f_busy_rdata", if_rdata, 32'd0);
      step();
      mem_rvalid = 1'b1; mem_rdata = 32'h0050_0093;
      #1;
      chk("f_if_rvalid", {31'd0, if_rvalid}, 32'd1);
      chk("f_if_rdata", if_rdata, 32'h0050_0093);
      chk("f_d_rvalid", {31'd0, d_rvalid}, 32'd0);
      chk("f_d_rdata", d_rdata, 32'd0);
      chk("f_no_gnt_on_ack", {31'd0, if_gnt}, 32'd0);
      step();
      if_req = 1'b0; mem_rvalid = 1'b0; mem_gnt = 1'b0;
      #1;
      chk("f_back_idle", {31'd0, mem_req}, 32'd0);
      chk("f_err", {31'd0, err}, 32'd0);

      // Collision: data write wins, fetch follows.
      step();
      if_req = 1'b1; if_addr = 32'h0000_0104;
      d_req = 1'b1; d_we = 1'b1; d_addr = 32'h0000_2000;
      d_wdata = 32'hDEAD_BEEF; d_be = 4'hF; mem_gnt = 1'b1;
      #1;
      chk("c_d_gnt", {31'd0, d_gnt}, 32'd1);
      chk("c_if_gnt", {31'd0, if_gnt}, 32'd0);
      chk("c_mem_we", {31'd0, mem_we}, 32'd1);
      chk("c_mem_addr", mem_addr, 32'h0000_2000);
      chk("c_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
      step();
      d_req = 1'b0; d_we = 1'b0;
      #1;
      chk("c_busy_req", {31'd0, mem_req}, 32'd0);
      step();
      mem_rvalid = 1'b1; mem_rdata = 32'h1234_5678;
      #1;
      chk("c_d_rvalid", {31'd0, d_rvalid}, 32'd1);
      chk("c_if_rvalid", {31'd0, if_rvalid}, 32'd0);
      chk("c_if_gnt_on_ack", {31'd0, if_gnt}, 32'd0);
      step();
      mem_rvalid = 1'b0;
      #1;
      chk("c_fetch_gnt", {31'd0, if_gnt}, 32'd1);
      chk("c_fetch_addr", mem_addr, 32'h0000_0104);
      step();
      if_req = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hAAAA_0001;
      #1;
      chk("c_fetch_rdata", if_rdata, 32'hAAAA_0001);
      step();
      mem_rvalid = 1'b0;

      // Stalled memory, data request arrives at cycle 3.
      if_req = 1'b1; if_addr = 32'h0000_0200;
      for (int c = 0; c < 5; c++) begin
         if (c == 3) begin
            d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_3000; d_be = 4'h3;
         end
         #1;
         chk("s_mem_req", {31'd0, mem_req}, 32'd1);
         chk("s_no_gnt", {30'd0, if_gnt, d_gnt}, 32'd0);
         chk("s_mem_addr", mem_addr, (c < 3) ? 32'h0000_0200 : 32'h0000_3000);
         step();
      end
      mem_gnt = 1'b1;
      #1;
      chk("s_d_gnt", {31'd0, d_gnt}, 32'd1);
      chk("s_if_gnt", {31'd0, if_gnt}, 32'd0);
      chk("s_mem_be", {28'd0, mem_be}, 32'h3);
      step();
      d_req = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hCAFE_0001;
      #1;
      chk("s_d_rdata", d_rdata, 32'hCAFE_0001);
      step();
      mem_rvalid = 1'b0; mem_gnt = 1'b1;
      #1;
      chk("s_fetch_gnt", {31'd0, if_gnt}, 32'd1);
      step();
      if_req = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b1;
      step();
      mem_rvalid = 1'b0;

      // Both requesters held continuously.
      if_req = 1'b1; if_addr = 32'h0000_0300;
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_4000; d_be = 4'hF;
      for (int g = 0; g < 6; g++) begin
         mem_gnt = 1'b1; mem_rvalid = 1'b0;
         #1;
         chk("st_d_gnt", {31'd0, d_gnt}, {31'd0, starve_seq[g]});
         chk("st_if_gnt", {31'd0, if_gnt}, {31'd0, ~starve_seq[g]});
         step();
         mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h0000_0F00 + g;
         #1;
         chk("st_d_rvalid", {31'd0, d_rvalid}, {31'd0, starve_seq[g]});
         step();
      end
      if_req = 1'b0; d_req = 1'b0; mem_rvalid = 1'b0;

      // Reset in the middle of a data transaction.
      step();
      d_req = 1'b1; d_we = 1'b1; d_addr = 32'h0000_5000; mem_gnt = 1'b1;
      #1;
      chk("r_d_gnt", {31'd0, d_gnt}, 32'd1);
      step();
      d_req = 1'b0; mem_gnt = 1'b0;
      #1;
      reset_n = 1'b0;
      #1;
      chk("r_rst_req", {31'd0, mem_req}, 32'd0);
      step();
      reset_n = 1'b1;
      step();
      mem_rvalid = 1'b1; mem_rdata = 32'h7777_7777;
      #1;
      chk("r_d_rvalid", {31'd0, d_rvalid}, 32'd0);
      chk("r_d_rdata", d_rdata, 32'd0);
      step();
      mem_rvalid = 1'b0;
      #1;
      chk("r_err_set", {31'd0, err}, 32'd1);
      reset_n = 1'b0;
      #1;
      chk("r_err_clr_async", {31'd0, err}, 32'd0);
      step();
      reset_n = 1'b1;

      // Spurious response in IDLE.
      step();
      mem_rvalid = 1'b1; mem_rdata = 32'h9999_0000;
      #1;
      chk("sp_rvalids", {30'd0, if_rvalid, d_rvalid}, 32'd0);
      chk("sp_err_before", {31'd0, err}, 32'd0);
      step();
      mem_rvalid = 1'b0;
      #1;
      chk("sp_err_set", {31'd0, err}, 32'd1);
      step(); step();
      #1;
      chk("sp_err_sticky", {31'd0, err}, 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
